// File: rtl/iec_bus_hub.sv
// IEC serial-bus junction: wired-AND of host and drive lines, synchronised and
// glitch-filtered bus levels, ATN edge pulses, idle and stuck-line status.
module iec_bus_hub #(
  parameter int unsigned N_DEV        = 4,
  parameter int unsigned FILT_LEN     = 16,
  parameter int unsigned IDLE_CYCLES  = 1024,
  parameter int unsigned STUCK_CYCLES = 65536
) (
  input  logic             clk32,
  input  logic             reset,
  input  logic             host_atn_out,
  input  logic             host_clk_out,
  input  logic             host_data_out,
  input  logic [N_DEV-1:0] dev_en,
  input  logic [N_DEV-1:0] dev_clk_out,
  input  logic [N_DEV-1:0] dev_data_out,
  output logic             bus_atn,
  output logic             bus_clk,
  output logic             bus_data,
  output logic             atn_fall,
  output logic             atn_rise,
  output logic [N_DEV-1:0] clk_pullers,
  output logic [N_DEV-1:0] data_pullers,
  output logic             idle,
  output logic             stuck_clk,
  output logic             stuck_data
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  localparam int unsigned ICW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned SCW = $clog2(STUCK_CYCLES + 1);

  localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILT_LEN - 1);
  localparam logic [ICW-1:0] IDLE_MAX   = ICW'(IDLE_CYCLES);
  localparam logic [ICW-1:0] IDLE_LAST  = ICW'(IDLE_CYCLES - 1);
  localparam logic [SCW-1:0] STUCK_MAX  = SCW'(STUCK_CYCLES);
  localparam logic [SCW-1:0] STUCK_LAST = SCW'(STUCK_CYCLES - 1);

  // Line index: 0 = ATN, 1 = CLK, 2 = DATA.
  logic [2:0]     raw;
  logic [2:0]     s1_q, s2_q;
  logic [2:0]     filt_q, filt_d;
  logic [FCW-1:0] fcnt_q [3];
  logic [FCW-1:0] fcnt_d [3];

  logic [ICW-1:0] idle_cnt_q;
  logic           idle_q;
  logic [SCW-1:0] stuck_cnt_q [2];
  logic [1:0]     stuck_q;
  logic           atn_fall_q, atn_rise_q;
  logic [N_DEV-1:0] clk_pull_q, data_pull_q;

  always_comb begin
    raw[0] = host_atn_out;
    raw[1] = host_clk_out & (&(dev_clk_out | ~dev_en));
    raw[2] = host_data_out & (&(dev_data_out | ~dev_en));
  end

  // A new level must be seen at s2 for FILT_LEN consecutive samples before it is taken.
  always_comb begin
    for (int l = 0; l < 3; l++) begin
      filt_d[l] = filt_q[l];
      fcnt_d[l] = '0;
      if (s2_q[l] != filt_q[l]) begin
        if (fcnt_q[l] == FILT_LAST) begin
          filt_d[l] = s2_q[l];
        end else begin
          fcnt_d[l] = fcnt_q[l] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      s1_q   <= '1;
      s2_q   <= '1;
      filt_q <= '1;
      for (int l = 0; l < 3; l++) begin
        fcnt_q[l] <= '0;
      end
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      for (int l = 0; l < 3; l++) begin
        fcnt_q[l] <= fcnt_d[l];
      end
    end
  end

  // Status logic looks at the next filtered value so it moves on the same edge as the bus.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      atn_fall_q  <= 1'b0;
      atn_rise_q  <= 1'b0;
      clk_pull_q  <= '0;
      data_pull_q <= '0;
    end else begin
      atn_fall_q  <= filt_q[0] & ~filt_d[0];
      atn_rise_q  <= ~filt_q[0] & filt_d[0];
      clk_pull_q  <= dev_en & ~dev_clk_out;
      data_pull_q <= dev_en & ~dev_data_out;
    end
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
      idle_q     <= 1'b0;
    end else if (!(&filt_d)) begin
      idle_cnt_q <= '0;
      idle_q     <= 1'b0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
      if (idle_cnt_q == IDLE_LAST) begin
        idle_q <= 1'b1;
      end
    end
  end

  // Index 0 tracks CLK, index 1 tracks DATA.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      stuck_q <= '0;
      for (int l = 0; l < 2; l++) begin
        stuck_cnt_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (filt_d[l+1]) begin
          stuck_cnt_q[l] <= '0;
          stuck_q[l]     <= 1'b0;
        end else if (!filt_q[l+1] && (stuck_cnt_q[l] != STUCK_MAX)) begin
          stuck_cnt_q[l] <= stuck_cnt_q[l] + 1'b1;
          if (stuck_cnt_q[l] == STUCK_LAST) begin
            stuck_q[l] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus_atn      = filt_q[0];
  assign bus_clk      = filt_q[1];
  assign bus_data     = filt_q[2];
  assign atn_fall     = atn_fall_q;
  assign atn_rise     = atn_rise_q;
  assign clk_pullers  = clk_pull_q;
  assign data_pullers = data_pull_q;
  assign idle         = idle_q;
  assign stuck_clk    = stuck_q[0];
  assign stuck_data   = stuck_q[1];

endmodule

// File: tb/tb_iec_bus_hub.sv
// Bench for iec_bus_hub: directed scenarios plus randomized traffic checked
// against a sliding-window / run-length reference model.
module tb_iec_bus_hub;

  localparam int N  = 4;
  localparam int FL = 16;
  localparam int IC = 1024;
  localparam int SC = 64;

  logic         clk32 = 1'b0;
  logic         reset = 1'b1;
  logic         host_atn_out = 1'b1, host_clk_out = 1'b1, host_data_out = 1'b1;
  logic [N-1:0] dev_en = '1, dev_clk_out = '1, dev_data_out = '1;
  logic         bus_atn, bus_clk, bus_data, atn_fall, atn_rise;
  logic [N-1:0] clk_pullers, data_pullers;
  logic         idle, stuck_clk, stuck_data;

  int errors = 0;
  int checks = 0;

  iec_bus_hub #(
    .N_DEV(N), .FILT_LEN(FL), .IDLE_CYCLES(IC), .STUCK_CYCLES(SC)
  ) dut (
    .clk32(clk32), .reset(reset),
    .host_atn_out(host_atn_out), .host_clk_out(host_clk_out), .host_data_out(host_data_out),
    .dev_en(dev_en), .dev_clk_out(dev_clk_out), .dev_data_out(dev_data_out),
    .bus_atn(bus_atn), .bus_clk(bus_clk), .bus_data(bus_data),
    .atn_fall(atn_fall), .atn_rise(atn_rise),
    .clk_pullers(clk_pullers), .data_pullers(data_pullers),
    .idle(idle), .stuck_clk(stuck_clk), .stuck_data(stuck_data)
  );

  always #5 clk32 = ~clk32;

  // Reference model state: raw samples of the last FL+2 edges, filtered levels and run lengths.
  logic [2:0]   m_hist [$];
  logic [2:0]   m_out;
  logic         m_fall, m_rise, m_idle, m_stk_clk, m_stk_data;
  logic [N-1:0] m_cp, m_dp;
  int           m_idle_run, m_clk_low, m_data_low;

  function automatic logic [2:0] raw_now();
    logic c, d;
    c = host_clk_out;
    d = host_data_out;
    for (int i = 0; i < N; i++) begin
      if (dev_en[i] && !dev_clk_out[i]) c = 1'b0;
      if (dev_en[i] && !dev_data_out[i]) d = 1'b0;
    end
    return {d, c, host_atn_out};
  endfunction

  task automatic model_reset();
    m_hist = {};
    for (int k = 0; k < FL + 2; k++) m_hist.push_back(3'b111);
    m_out = 3'b111;
    m_fall = 0; m_rise = 0; m_idle = 0; m_stk_clk = 0; m_stk_data = 0;
    m_cp = '0; m_dp = '0;
    m_idle_run = 0; m_clk_low = 0; m_data_low = 0;
  endtask

  // One clock edge; model advances on the values the DUT samples; returns 1ns after the edge.
  task automatic cycle();
    logic [2:0] prev;
    bit flip;
    @(posedge clk32);
    if (reset) begin
      model_reset();
    end else begin
      m_hist.push_back(raw_now());
      void'(m_hist.pop_front());
      prev = m_out;
      for (int l = 0; l < 3; l++) begin
        flip = 1;
        for (int k = 0; k < FL; k++) if (m_hist[k][l] == prev[l]) flip = 0;
        if (flip) m_out[l] = ~prev[l];
      end
      m_fall = prev[0] & ~m_out[0];
      m_rise = ~prev[0] & m_out[0];
      m_cp = dev_en & ~dev_clk_out;
      m_dp = dev_en & ~dev_data_out;
      m_idle_run = (&m_out) ? m_idle_run + 1 : 0;
      m_clk_low  = m_out[1] ? 0 : m_clk_low + 1;
      m_data_low = m_out[2] ? 0 : m_data_low + 1;
      m_idle     = (m_idle_run >= IC);
      m_stk_clk  = (m_clk_low > SC);
      m_stk_data = (m_data_low > SC);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    dev_clk_out = 4'b0000;
    dev_data_out = 4'b0000;
    cycle();
    checks++;
    if ({bus_atn, bus_clk, bus_data} !== 3'b111) begin
      errors++; $display("FAIL reset_bus got %b exp 111", {bus_atn, bus_clk, bus_data});
    end
    checks++;
    if ({atn_fall, atn_rise, idle, stuck_clk, stuck_data} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000",
                         {atn_fall, atn_rise, idle, stuck_clk, stuck_data});
    end
    checks++;
    if ({clk_pullers, data_pullers} !== 8'h00) begin
      errors++; $display("FAIL reset_pullers got %h exp 00", {clk_pullers, data_pullers});
    end
    dev_clk_out = '1;
    dev_data_out = '1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int k = 1; k <= IC + 6; k++) begin
      cycle();
      checks++;
      if (idle !== (k >= IC)) begin
        errors++; $display("FAIL idle_edge%0d got %b exp %b", k, idle, (k >= IC));
      end
      checks++;
      if ({atn_fall, atn_rise} !== 2'b00) begin
        errors++; $display("FAIL idle_no_pulse edge%0d got %b exp 00", k, {atn_fall, atn_rise});
      end
    end
  endtask

  task automatic test_atn();
    host_atn_out = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      cycle();
      checks++;
      if (bus_atn !== (k < FL + 2)) begin
        errors++; $display("FAIL atn_fall_bus edge%0d got %b exp %b", k, bus_atn, (k < FL + 2));
      end
      checks++;
      if (atn_fall !== (k == FL + 2) || atn_rise !== 1'b0) begin
        errors++; $display("FAIL atn_fall_pulse edge%0d got %b%b exp %b0", k, atn_fall, atn_rise,
                           (k == FL + 2));
      end
      checks++;
      if (idle !== (k < FL + 2)) begin
        errors++; $display("FAIL atn_idle edge%0d got %b exp %b", k, idle, (k < FL + 2));
      end
    end
    host_atn_out = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      cycle();
      checks++;
      if (bus_atn !== (k >= FL + 2)) begin
        errors++; $display("FAIL atn_rise_bus edge%0d got %b exp %b", k, bus_atn, (k >= FL + 2));
      end
      checks++;
      if (atn_rise !== (k == FL + 2) || atn_fall !== 1'b0) begin
        errors++; $display("FAIL atn_rise_pulse edge%0d got %b%b exp 0%b", k, atn_fall, atn_rise,
                           (k == FL + 2));
      end
    end
  endtask

  task automatic test_glitch();
    dev_en = 4'b1111;
    dev_data_out = 4'b1011;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      checks++;
      if (data_pullers !== 4'b0100 || bus_data !== 1'b1) begin
        errors++; $display("FAIL glitch_hold edge%0d got pullers=%b bus=%b exp 0100/1", k,
                           data_pullers, bus_data);
      end
    end
    dev_data_out = 4'b1111;
    for (int k = 1; k <= 25; k++) begin
      cycle();
      checks++;
      if (data_pullers !== 4'b0000 || bus_data !== 1'b1) begin
        errors++; $display("FAIL glitch_after edge%0d got pullers=%b bus=%b exp 0000/1", k,
                           data_pullers, bus_data);
      end
    end
  endtask

  task automatic test_disabled();
    dev_en = 4'b1101;
    dev_clk_out = 4'b1101;
    for (int k = 1; k <= 25; k++) begin
      cycle();
      checks++;
      if (bus_clk !== 1'b1 || clk_pullers !== 4'b0000) begin
        errors++; $display("FAIL disabled_clk edge%0d got bus=%b pullers=%b exp 1/0000", k,
                           bus_clk, clk_pullers);
      end
    end
    dev_en = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if (bus_clk !== (k < FL + 2) || clk_pullers !== 4'b0010) begin
        errors++; $display("FAIL enabled_clk edge%0d got bus=%b pullers=%b exp %b/0010", k,
                           bus_clk, clk_pullers, (k < FL + 2));
      end
    end
    dev_clk_out = 4'b1111;
    repeat (20) cycle();
  endtask

  task automatic test_stuck();
    host_data_out = 1'b0;
    for (int k = 1; k <= FL + 2 + SC + 4; k++) begin
      cycle();
      checks++;
      if (stuck_data !== (k >= FL + 2 + SC) || stuck_clk !== 1'b0) begin
        errors++; $display("FAIL stuck_set edge%0d got %b exp %b", k, stuck_data,
                           (k >= FL + 2 + SC));
      end
    end
    host_data_out = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if (bus_data !== (k >= FL + 2) || stuck_data !== (k < FL + 2)) begin
        errors++; $display("FAIL stuck_clear edge%0d got bus=%b stuck=%b exp %b/%b", k,
                           bus_data, stuck_data, (k >= FL + 2), (k < FL + 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int falls;
    host_atn_out = 1'b0;
    repeat (7) cycle();
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus_atn !== 1'b1 || atn_fall !== 1'b0) begin
      errors++; $display("FAIL midreset_bus got %b%b exp 10", bus_atn, atn_fall);
    end
    cycle();
    reset = 1'b0;
    falls = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (atn_fall === 1'b1) falls++;
      checks++;
      if (bus_atn !== (k < FL + 2)) begin
        errors++; $display("FAIL midreset_fall edge%0d got %b exp %b", k, bus_atn, (k < FL + 2));
      end
    end
    checks++;
    if (falls != 1) begin
      errors++; $display("FAIL midreset_pulses got %0d exp 1", falls);
    end
    host_atn_out = 1'b1;
    repeat (20) cycle();
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    int hold;
    do_reset();
    for (int seg = 0; seg < 180; seg++) begin
      if ($urandom_range(0, 11) == 0) begin
        hold = $urandom_range(80, 1100);
        host_atn_out = 1; host_clk_out = 1; host_data_out = 1;
        dev_en = 4'($urandom); dev_clk_out = '1; dev_data_out = 4'($urandom) | ~dev_en;
      end else begin
        hold = $urandom_range(1, 40);
        host_atn_out  = ($urandom_range(0, 2) != 0);
        host_clk_out  = ($urandom_range(0, 2) != 0);
        host_data_out = ($urandom_range(0, 2) != 0);
        dev_en       = 4'($urandom);
        dev_clk_out  = 4'($urandom) | 4'($urandom);
        dev_data_out = 4'($urandom) | 4'($urandom);
      end
      for (int k = 0; k < hold; k++) begin
        cycle();
        got = {bus_atn, bus_clk, bus_data, atn_fall, atn_rise, idle, stuck_clk, stuck_data,
               clk_pullers, data_pullers};
        exp = {m_out[0], m_out[1], m_out[2], m_fall, m_rise, m_idle, m_stk_clk, m_stk_data,
               m_cp, m_dp};
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL random seg%0d cyc%0d got %h exp %h", seg, k, got, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_atn();
    test_glitch();
    test_disabled();
    test_stuck();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
